pc_predict: RTL

PC_PREDICT -- requirements
Module: pc_predict

---
 rtl/pc_predict.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pc_predict.sv
`default_nettype none
// ============================================================================
//  Module   : pc_predict
//  Purpose  : Fetch PC generator with EX-stage branch resolution, mispredict
//             flush, halt FSM and optional direct-mapped BTB with 2-bit
//             counters (enabled by defining PC_PREDICT_BTB_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module pc_predict #(
   parameter int ADDR_W    = 16,
   parameter int IMM_W     = 9,
   parameter int BTB_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              halt,
   output logic [ADDR_W-1:0] pc,
   output logic              pred_taken,
   input  logic              ex_valid,
   input  logic [ADDR_W-1:0] ex_pc,
   input  logic [2:0]        ex_cond,
   input  logic [2:0]        ex_flags,
   input  logic              ex_is_reg,
   input  logic [IMM_W-1:0]  ex_imm,
   input  logic [ADDR_W-1:0] ex_reg_target,
   input  logic              ex_pred_taken,
   input  logic [ADDR_W-1:0] ex_pred_target,
   output logic              flush,
   output logic              halted
);

   localparam int IDX_W = (BTB_DEPTH > 1) ? $clog2(BTB_DEPTH) : 1;
   localparam int TAG_W = ADDR_W - IDX_W - 1;

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);

   generate
      if ((BTB_DEPTH < 2) || ((1 << IDX_W) != BTB_DEPTH) || (IMM_W >= ADDR_W) || (TAG_W < 1)) begin : g_bad_cfg
         $error("pc_predict: unsupported parameter set");
      end
   endgenerate

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [0:0]        state_q, state_d;
   logic              is_halted;
   logic              ex_go;
   logic              flag_z, flag_v, flag_n;
   logic              cond_true;
   logic              actual_taken;
   logic [ADDR_W-1:0] imm_ext;
   logic [ADDR_W-1:0] br_target;
   logic              btb_taken;
   logic [ADDR_W-1:0] btb_target;

   assign is_halted = (state_q == ST_HALTED);
   assign ex_go     = ex_valid & ~stall;
   assign {flag_z, flag_v, flag_n} = ex_flags;

   always_comb begin
      cond_true = 1'b0;
      case (ex_cond)
         3'b000:  cond_true = ~flag_z;
         3'b001:  cond_true = flag_z;
         3'b010:  cond_true = ~flag_n & ~flag_z;
         3'b011:  cond_true = flag_n;
         3'b100:  cond_true = flag_z | ~flag_n;
         3'b101:  cond_true = flag_n | flag_z;
         3'b110:  cond_true = flag_v;
         default: cond_true = 1'b1;
      endcase
   end

   // Immediate is a signed halfword offset; the add wraps modulo 2^ADDR_W.
   assign imm_ext      = {{(ADDR_W-IMM_W){ex_imm[IMM_W-1]}}, ex_imm};
   assign br_target    = ex_is_reg ? ex_reg_target : (ex_pc + (imm_ext << 1));
   assign actual_taken = ex_go & cond_true;

   assign flush = ex_go & ~is_halted &
                  ((actual_taken != ex_pred_taken) |
                   (actual_taken & (ex_pred_target != br_target)));

   always_comb begin
      pc_d = pc_q + PC_STEP;
      if (flush) begin
         pc_d = actual_taken ? br_target : (ex_pc + PC_STEP);
      end else if (stall || is_halted) begin
         pc_d = pc_q;
      end else if (btb_taken) begin
         pc_d = btb_target;
      end
   end

   // Halt coinciding with a redirect is dropped: the halt was on the wrong path.
   always_comb begin
      state_d = state_q;
      if ((state_q == ST_RUN) && halt && !flush) begin
         state_d = ST_HALTED;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= '0;
         state_q <= ST_RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

`ifdef PC_PREDICT_BTB_EN
   logic [BTB_DEPTH-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
   logic [TAG_W-1:0]     tag_d [BTB_DEPTH];
   logic [ADDR_W-1:0]    tgt_q [BTB_DEPTH];
   logic [ADDR_W-1:0]    tgt_d [BTB_DEPTH];
   logic [1:0]           ctr_q [BTB_DEPTH];
   logic [1:0]           ctr_d [BTB_DEPTH];
   logic [IDX_W-1:0]     f_idx, e_idx;
   logic [TAG_W-1:0]     f_tag, e_tag;
   logic                 f_hit, e_hit;

   assign f_idx = pc_q[IDX_W:1];
   assign f_tag = pc_q[ADDR_W-1:IDX_W+1];
   assign e_idx = ex_pc[IDX_W:1];
   assign e_tag = ex_pc[ADDR_W-1:IDX_W+1];

   assign f_hit      = valid_q[f_idx] & (tag_q[f_idx] == f_tag);
   assign e_hit      = valid_q[e_idx] & (tag_q[e_idx] == e_tag);
   assign btb_taken  = f_hit & ctr_q[f_idx][1];
   assign btb_target = tgt_q[f_idx];

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      ctr_d   = ctr_q;
      if (ex_go && !is_halted) begin
         if (e_hit) begin
            if (actual_taken) begin
               tgt_d[e_idx] = br_target;
               if (ctr_q[e_idx] != 2'b11) ctr_d[e_idx] = ctr_q[e_idx] + 2'b01;
            end else if (ctr_q[e_idx] != 2'b00) begin
               ctr_d[e_idx] = ctr_q[e_idx] - 2'b01;
            end
         end else if (actual_taken) begin
            valid_d[e_idx] = 1'b1;
            tag_d[e_idx]   = e_tag;
            tgt_d[e_idx]   = br_target;
            ctr_d[e_idx]   = 2'b10;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < BTB_DEPTH; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            ctr_q[i] <= 2'b01;
         end
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         tgt_q   <= tgt_d;
         ctr_q   <= ctr_d;
      end
   end
`else
   assign btb_taken  = 1'b0;
   assign btb_target = '0;
`endif

   assign pc         = pc_q;
   assign halted     = is_halted;
   assign pred_taken = btb_taken & ~is_halted;

endmodule
`default_nettype wire
